// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between VGA scanout and
// two round-robin requesters.
//   - Display fetch slot: one word per 8 pixels, fetched one word ahead of the beam.
//   - All other cycles go to req0/req1, alternating when both are requesting.
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   x_pos, y_pos                10-bit timing counters (wrap mod 1024)
//   req*/addr*/we*/wdata*       requester access (req held until gnt)
//   gnt*                        combinational grant, high in the decision cycle
//   rvalid*, rdata              requester read return, 2 cycles after gnt
//   disp_dvalid/word/data       display word return, 2 cycles after its slot
//   ram_en/we/addr/wdata        registered VRAM command
//   ram_rdata                   VRAM read data, 1 cycle after a read command
module vram_arbiter #(
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       WORDS_LINE = 80,
   parameter int unsigned       LINES      = 480,
   parameter logic [ADDR_W-1:0] FB_BASE    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        x_pos,
   input  logic [9:0]        y_pos,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic              we0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic              we1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              disp_dvalid,
   output logic [6:0]        disp_word,
   output logic [DATA_W-1:0] disp_data,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [9:0] X_END = 10'(WORDS_LINE * 8);
   localparam logic [9:0] Y_END = 10'(LINES);

   logic [9:0]        xp8;
   logic              disp_slot;
   logic [ADDR_W-1:0] disp_addr;
   // Set when the last grant went to req0, so req1 wins the next tie.
   logic              prio1_q;
   // Stage-1 tags: what the command now on ram_* will return next cycle.
   logic              rd0_q, rd1_q, disp_q;
   logic [6:0]        word_q;

   always_comb begin
      xp8       = x_pos + 10'd8;
      disp_slot = (xp8[2:0] == 3'd0) && (xp8 < X_END) && (y_pos < Y_END);
      // Multiply in ADDR_W so the line offset truncates to the address width.
      disp_addr = FB_BASE + ADDR_W'(y_pos) * ADDR_W'(WORDS_LINE) + ADDR_W'(xp8[9:3]);
      gnt0      = !rst && !disp_slot && req0 && (!req1 || !prio1_q);
      gnt1      = !rst && !disp_slot && req1 && (!req0 || prio1_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio1_q     <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         rd0_q       <= 1'b0;
         rd1_q       <= 1'b0;
         disp_q      <= 1'b0;
         word_q      <= '0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         disp_dvalid <= 1'b0;
         disp_word   <= '0;
      end else begin
         if (gnt0) begin
            prio1_q <= 1'b1;
         end else if (gnt1) begin
            prio1_q <= 1'b0;
         end

         ram_en <= disp_slot | gnt0 | gnt1;
         if (disp_slot) begin
            ram_we   <= 1'b0;
            ram_addr <= disp_addr;
         end else if (gnt0) begin
            ram_we    <= we0;
            ram_addr  <= addr0;
            ram_wdata <= wdata0;
         end else if (gnt1) begin
            ram_we    <= we1;
            ram_addr  <= addr1;
            ram_wdata <= wdata1;
         end

         rd0_q  <= gnt0 & ~we0;
         rd1_q  <= gnt1 & ~we1;
         disp_q <= disp_slot;
         if (disp_slot) begin
            word_q <= xp8[9:3];
         end

         rvalid0     <= rd0_q;
         rvalid1     <= rd1_q;
         disp_dvalid <= disp_q;
         if (disp_q) begin
            disp_word <= word_q;
         end
      end
   end

   // VRAM data arrives exactly when the matching valid is high; gating keeps the
   // data outputs at zero through reset and idle cycles.
   always_comb begin
      rdata     = (rvalid0 | rvalid1 | disp_dvalid) ? ram_rdata : '0;
      disp_data = disp_dvalid ? ram_rdata : '0;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural
// synchronous single-port RAM attached to the ram_* port.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  x_pos, y_pos;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, disp_dvalid;
   logic [7:0]  rdata, disp_data;
   logic [6:0]  disp_word;
   logic        ram_en, ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;

   int checks   = 0;
   int failures = 0;
   int disp_cnt = 0;
   bit expect_rd = 1'b1;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } ram_t;
   typedef struct packed {
      logic [6:0] word;
      logic [7:0] data;
   } disp_t;

   ram_t       ram_q[$];
   disp_t      disp_q[$];
   logic [7:0] rd0_q[$];
   logic [7:0] rd1_q[$];

   logic [7:0] mem [65536];

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
      .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
      .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .disp_dvalid(disp_dvalid), .disp_word(disp_word), .disp_data(disp_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5a;
   endfunction

   always @(posedge clk) begin
      if (ram_en === 1'b1) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard pops: every VRAM command and every returned word.
   always @(negedge clk) begin
      ram_t       r;
      disp_t      d;
      logic [7:0] e;
      if (ram_en === 1'b1) begin
         if (ram_q.size() == 0) check_eq("ram_en_unexpected", 1, 0);
         else begin
            r = ram_q.pop_front();
            check_eq("ram_we", ram_we, r.we);
            check_eq("ram_addr", ram_addr, r.addr);
            if (r.we) check_eq("ram_wdata", ram_wdata, r.wdata);
         end
      end
      if (rvalid0 === 1'b1) begin
         if (rd0_q.size() == 0) check_eq("rvalid0_unexpected", 1, 0);
         else begin
            e = rd0_q.pop_front();
            check_eq("rdata0", rdata, e);
         end
      end
      if (rvalid1 === 1'b1) begin
         if (rd1_q.size() == 0) check_eq("rvalid1_unexpected", 1, 0);
         else begin
            e = rd1_q.pop_front();
            check_eq("rdata1", rdata, e);
         end
      end
      if (disp_dvalid === 1'b1) begin
         disp_cnt++;
         if (disp_q.size() == 0) check_eq("disp_unexpected", 1, 0);
         else begin
            d = disp_q.pop_front();
            check_eq("disp_word", disp_word, d.word);
            check_eq("disp_data", disp_data, d.data);
            check_eq("disp_rdata", rdata, d.data);
         end
      end
   end

   // One cycle: drive after the edge, check grants mid-cycle, push expectations.
   task automatic run_cycle(input int x, input int y,
                            input bit r0, input bit w0, input logic [15:0] a0,
                            input logic [7:0] d0,
                            input bit r1, input bit w1, input logic [15:0] a1,
                            input logic [7:0] d1,
                            input bit eg0, input bit eg1);
      int xp8, a;
      @(posedge clk);
      #1;
      x_pos = 10'(x); y_pos = 10'(y);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      check_eq("gnt0", gnt0, eg0);
      check_eq("gnt1", gnt1, eg1);
      xp8 = (x + 8) % 1024;
      if (xp8 % 8 == 0 && xp8 < 640 && y < 480) begin
         a = y * 80 + xp8 / 8;
         ram_q.push_back('{we: 1'b0, addr: 16'(a), wdata: 8'h00});
         disp_q.push_back('{word: 7'(xp8 / 8), data: pat(16'(a))});
      end
      if (eg0) begin
         ram_q.push_back('{we: w0, addr: a0, wdata: d0});
         if (!w0 && expect_rd) rd0_q.push_back(pat(a0));
      end
      if (eg1) begin
         ram_q.push_back('{we: w1, addr: a1, wdata: d1});
         if (!w1 && expect_rd) rd1_q.push_back(pat(a1));
      end
   endtask

   task automatic idle(input int n, input int y);
      for (int i = 0; i < n; i++) run_cycle(700, y, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      ram_rdata = 8'h00;
      rst = 1'b1; x_pos = 10'd700; y_pos = 10'd500;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0042; wdata0 = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 8'h00;

      // 1: reset with a request pending.
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check_eq("rst_gnt0", gnt0, 0);
      check_eq("rst_ram_en", ram_en, 0);
      check_eq("rst_ram_we", ram_we, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_wdata", ram_wdata, 0);
      check_eq("rst_rvalid", {rvalid0, rvalid1, disp_dvalid}, 0);
      check_eq("rst_disp_word", disp_word, 0);
      check_eq("rst_data", {rdata, disp_data}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; req0 = 1'b0;

      // 2: display sweep on line 5, x 1010 wrapping to 640 (80 fetches, 400..479).
      for (int xi = 1010; xi <= 1024 + 640; xi++)
         run_cycle(xi % 1024, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3, 5);
      check_eq("disp_count", disp_cnt, 80);

      // 3: request collides with the display slot at x=8, granted at x=9.
      for (int x = 4; x < 8; x++) run_cycle(x, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle(8, 0, 1, 0, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
      run_cycle(9, 0, 1, 0, 16'h1234, 0, 0, 0, 0, 0, 1, 0);
      for (int x = 10; x < 14; x++) run_cycle(x, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // 4: both requesting in blanking; last grant was req0, so req1 leads.
      for (int i = 0; i < 6; i++)
         run_cycle(700, 500, 1, 1, 16'h0100 + 16'(i), 8'ha0 + 8'(i),
                   1, 0, 16'h0200 + 16'(i), 0, i[0], !i[0]);
      idle(3, 500);

      // 5: req1 alone back-to-back, then a tie goes to req0.
      for (int i = 0; i < 4; i++)
         run_cycle(700, 500, 0, 0, 0, 0, 1, 0, 16'h0210 + 16'(i), 0, 0, 1);
      run_cycle(700, 500, 1, 0, 16'h0220, 0, 1, 0, 16'h0221, 0, 1, 0);
      run_cycle(700, 500, 1, 0, 16'h0222, 0, 1, 0, 16'h0221, 0, 0, 1);
      idle(3, 500);

      // 6: reset one cycle after a read grant drops the read; pointer resets.
      expect_rd = 1'b0;
      run_cycle(700, 500, 1, 0, 16'h0300, 0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_gnt0", gnt0, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rst_mid_rvalid0", rvalid0, 0);
      check_eq("rst_mid_ram_en", ram_en, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_rd = 1'b1;
      @(negedge clk);
      check_eq("post_rst_gnt0", gnt0, 1);
      ram_q.push_back('{we: 1'b0, addr: 16'h0300, wdata: 8'h00});
      rd0_q.push_back(pat(16'h0300));
      run_cycle(700, 500, 1, 0, 16'h0301, 0, 1, 0, 16'h0302, 0, 0, 1);
      idle(4, 500);

      check_eq("ram_q_left", ram_q.size(), 0);
      check_eq("disp_q_left", disp_q.size(), 0);
      check_eq("rd0_q_left", rd0_q.size(), 0);
      check_eq("rd1_q_left", rd1_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
